if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch stage ahead of `if_id`. Owns the program counter, issues word-aligned requests to instruction memory over a request/grant, in-order response bus, and buffers returned instructions in a small FIFO. It hands `{pc, instruction}` pairs downstream with valid/ready flow control. It accepts a redirect from EX (taken branch, JAL, JALR) that flushes all stale work.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: FIFO entries, and also the maximum of outstanding requests plus buffered entries. Must be a power of two and at least 2.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `o_imem_req`  out  1  fetch request.
- `o_imem_addr`  out  32  fetch address; bits [1:0] are always 0.
- `i_imem_gnt`  in  1  request accepted this cycle.
- `i_imem_rvalid`  in  1  response valid. Responses arrive one per grant, in order, at least 1 cycle after the grant.
- `i_imem_rdata`  in  32  instruction word.
- `i_redirect`  in  1  PC redirect from EX.
- `i_redirect_addr`  in  32  redirect target; bits [1:0] are ignored.
- `o_valid`  out  1  FIFO head is valid.
- `o_pc_addr`  out  32  PC of the head instruction.
- `o_inst_data`  out  32  head instruction; 32'h0000_0013 (NOP) when `o_valid` = 0.
- `i_ready`  in  1  downstream (`if_id`) accepts the head this cycle.

## Operation
- State machine:
  - BOOT, entered on reset: lasts exactly one cycle with no request, then moves to FETCH.
  - FETCH: the block stays here until the next reset.
- Registers:
  - `pc` (32 bits).
  - Outstanding counter `O` (0..DEPTH).
  - Discard counter `D` (0..O).
  - FIFO of DEPTH entries `{pc, inst}`, with count `C`.
  - Address FIFO of DEPTH entries holding the PCs of outstanding requests.
- Request generation: `o_imem_req` = FETCH && (O + C < DEPTH). `o_imem_addr` = `{pc[31:2], 2'b00}`.
- Request hold: once asserted, `o_imem_req` and `o_imem_addr` stay stable until `i_imem_gnt`, unless a redirect occurs.
- On a grant: `pc` <= `pc` + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0. The request PC is pushed into the address FIFO and `O` increments.
- On a response (`i_imem_rvalid`): `O` decrements and the address FIFO pops.
  - If `D` > 0: the response is dropped and `D` decrements.
  - Otherwise `{popped pc, i_imem_rdata}` is written to the FIFO.
- Pop: when `o_valid` && `i_ready`, the head is removed. `C` is updated as push − pop, so simultaneous push and pop is allowed.
- Redirect takes priority over every other update in the same cycle:
  - `pc` <= `{i_redirect_addr[31:2], 2'b00}`.
  - The FIFO is emptied (C <= 0); any same-cycle pop or push is void.
  - `D` <= `O` + gnt − rvalid, so every request in flight after this edge is discarded.
  - A grant in the redirect cycle still counts as outstanding and is discarded.
  - Back-to-back redirects are allowed; each recomputes `D` the same way.
- Arithmetic: `O + C` is computed at log2(DEPTH)+2 bits, so the sum never overflows.

## Timing
- Reset values:
  - `o_imem_req` = 0, `o_imem_addr` = `RESET_PC`.
  - `o_valid` = 0, `o_pc_addr` = 0, `o_inst_data` = 32'h0000_0013.
  - `pc` = `RESET_PC`; O, D, C = 0; state = BOOT.
- First `o_imem_req` is in the second cycle after `i_reset` deasserts.
- Response to output: `o_valid` rises the cycle after the accepted `i_imem_rvalid`. There is no combinational bypass.
- Full throughput: with grant every cycle, 1-cycle response latency and `i_ready` = 1, sustained output is 1 instruction per cycle. This requires `DEPTH` ≥ 3.
- Redirect:
  - Redirect asserted in cycle N: `o_valid` = 0 in N+1.
  - The new-target request is presented in N+1.
  - The earliest valid new-target instruction appears at N+3, or later if discards are pending.
- Full: when O + C = DEPTH, `o_imem_req` = 0. The request restarts in the cycle after a pop or a dropped response frees a slot.
- Empty: `o_valid` = 0 and `o_inst_data` = NOP; `i_ready` is ignored.
- Reset mid-operation clears everything immediately. Instruction memory is reset by the same `i_reset`, so no stale responses can arrive afterwards.

## Test plan
- Reset with `RESET_PC` = 32'h100, zero-wait memory (1-cycle latency), `i_ready` = 1:
  - Requests are issued at 0x100, 0x104, 0x108, …, one per cycle.
  - `o_pc_addr` streams 0x100, 0x104, 0x108, … with one instruction per cycle and no bubbles.
- `i_ready` held at 0 for 10 cycles:
  - `o_imem_req` falls once O + C = 4.
  - `o_valid` stays 1 with a stable head.
  - After release, 4 buffered instructions drain in order, then streaming resumes.
- Memory with 3-cycle latency, redirect to 32'h2003 while 2 requests are outstanding:
  - The next request address is 0x2000.
  - The 2 stale responses are dropped.
  - The first `o_pc_addr` after the redirect is 0x2000.
- Redirect in the same cycle as a pop and a response push:
  - The FIFO is empty next cycle.
  - The response is not written.
  - No instruction before the redirect appears afterwards.
- `pc` at 32'hFFFF_FFF8: requests go to 0xFFFF_FFF8, 0xFFFF_FFFC, then wrap to 0x0000_0000.
- `i_reset` asserted mid-stream with 2 entries buffered:
  - All outputs return to their reset values immediately.
  - After release, fetch restarts at `RESET_PC` after the one BOOT cycle.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC and issues word-aligned requests over a
// req/gnt bus with in-order responses. Returned words go into a small
// {pc, inst} FIFO that feeds if_id through valid/ready handshakes. A redirect
// from EX flushes the FIFO and drops every response still in flight.
`timescale 1ns/1ps
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    output logic        o_valid,
    output logic [31:0] o_pc_addr,
    output logic [31:0] o_inst_data,
    input  logic        i_ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;  // holds 0..DEPTH
    localparam int unsigned SW = AW + 2;  // O + C without overflow
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [0:0] {StBoot, StFetch} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;    // outstanding requests
    logic [CW-1:0] disc_q, disc_d;  // responses still to be dropped
    logic [CW-1:0] cnt_q, cnt_d;    // buffered instructions
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW-1:0] awr_q, awr_d, ard_q, ard_d;

    logic [31:0] addr_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [SW-1:0] occ_sum;
    logic          gnt_fire;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [1:0]    unused_redirect_bits;

    assign unused_redirect_bits = i_redirect_addr[1:0];

    assign occ_sum     = {1'b0, out_q} + {1'b0, cnt_q};
    assign o_imem_req  = (state_q == StFetch) && (occ_sum < SW'(DEPTH));
    assign o_imem_addr = {pc_q[31:2], 2'b00};
    assign gnt_fire    = o_imem_req && i_imem_gnt;
    assign resp_drop   = i_imem_rvalid && (disc_q != '0);
    // A redirect voids any same-cycle FIFO push or pop.
    assign push        = i_imem_rvalid && (disc_q == '0) && !i_redirect;
    assign pop         = o_valid && i_ready && !i_redirect;

    assign o_valid     = (cnt_q != '0);
    assign o_pc_addr   = o_valid ? pc_mem[rd_q] : 32'h0;
    assign o_inst_data = o_valid ? inst_mem[rd_q] : NOP;

    // Next-state: FSM, PC, counters and FIFO pointers; redirect wins over all.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disc_d  = disc_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        awr_d   = awr_q;
        ard_d   = ard_q;

        case (state_q)
            StBoot:  state_d = StFetch;
            StFetch: state_d = StFetch;
        endcase

        // The address FIFO tracks every granted request, redirect or not.
        out_d = out_q + CW'(gnt_fire) - CW'(i_imem_rvalid);
        if (gnt_fire) begin
            awr_d = awr_q + AW'(1);
        end
        if (i_imem_rvalid) begin
            ard_d = ard_q + AW'(1);
        end

        if (i_redirect) begin
            pc_d   = {i_redirect_addr[31:2], 2'b00};
            disc_d = out_d;
            cnt_d  = '0;
            wr_d   = '0;
            rd_d   = '0;
        end else begin
            if (gnt_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_drop) begin
                disc_d = disc_q - CW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            if (push) begin
                wr_d = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            awr_q   <= '0;
            ard_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            awr_q   <= awr_d;
            ard_q   <= ard_d;
        end
    end

    // FIFO storage; contents are only visible through the counted entries.
    always_ff @(posedge i_clk) begin
        if (gnt_fire) begin
            addr_mem[awr_q] <= o_imem_addr;
        end
        if (push) begin
            pc_mem[wr_q]   <= addr_mem[ard_q];
            inst_mem[wr_q] <= i_imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: behavioural instruction memory with programmable latency
// and grant enable, plus a scoreboard of expected {pc, inst} output pairs.
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        i_clk;
    logic        i_reset;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_addr;
    logic        o_valid;
    logic [31:0] o_pc_addr;
    logic [31:0] o_inst_data;
    logic        i_ready;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc       = 0;
    int          lat       = 1;
    bit          gnt_en    = 1'b1;
    int          grant_cnt = 0;
    int          pop_cnt   = 0;

    if_fetch #(
        .RESET_PC(RST_PC),
        .DEPTH   (4)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .i_redirect     (i_redirect),
        .i_redirect_addr(i_redirect_addr),
        .o_valid        (o_valid),
        .o_pc_addr      (o_pc_addr),
        .o_inst_data    (o_inst_data),
        .i_ready        (i_ready)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F13;
    endfunction

    task automatic load_stream(input logic [31:0] base);
        exp_q.delete();
        for (int k = 0; k < 256; k++) exp_q.push_back(base + 32'(k * 4));
    endtask

    // Instruction memory: inputs change 1ns after the falling edge.
    initial begin
        i_imem_gnt    = 1'b0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        forever begin
            @(negedge i_clk);
            #1;
            cyc++;
            if (!i_reset) begin
                pend_addr.delete();
                pend_due.delete();
                i_imem_gnt    = 1'b0;
                i_imem_rvalid = 1'b0;
                i_imem_rdata  = 32'h0;
            end else begin
                if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                    i_imem_rvalid = 1'b1;
                    i_imem_rdata  = inst_of(pend_addr[0]);
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end else begin
                    i_imem_rvalid = 1'b0;
                    i_imem_rdata  = 32'h0;
                end
                i_imem_gnt = gnt_en;
                if (gnt_en && o_imem_req) begin
                    pend_addr.push_back(o_imem_addr);
                    pend_due.push_back(cyc + lat);
                    grant_cnt++;
                end
            end
        end
    end

    // Scoreboard: every accepted output must match the next expected pair.
    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_reset && !i_redirect && o_valid && i_ready) begin
                pop_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++;
                    $display("FAIL sb_unexpected got pc=%h want no output", o_pc_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (o_pc_addr !== e || o_inst_data !== inst_of(e)) begin
                        n_fails++;
                        $display("FAIL sb_out got pc=%h inst=%h want pc=%h inst=%h",
                                 o_pc_addr, o_inst_data, e, inst_of(e));
                    end
                end
            end
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge i_clk);
        #2;
        n_checks++;
        if (o_imem_req !== 1'b0) begin
            n_fails++; $display("FAIL reset_req got=%b want=0", o_imem_req);
        end
        n_checks++;
        if (o_imem_addr !== RST_PC) begin
            n_fails++; $display("FAIL reset_addr got=%h want=%h", o_imem_addr, RST_PC);
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_valid got=%b want=0", o_valid);
        end
        n_checks++;
        if (o_pc_addr !== 32'h0) begin
            n_fails++; $display("FAIL reset_pc got=%h want=0", o_pc_addr);
        end
        n_checks++;
        if (o_inst_data !== NOP) begin
            n_fails++; $display("FAIL reset_inst got=%h want=%h", o_inst_data, NOP);
        end
        @(negedge i_clk);
        load_stream(RST_PC);
        i_reset = 1'b1;
        #2;
        n_checks++;
        if (o_imem_req !== 1'b0) begin
            n_fails++; $display("FAIL boot_req got=%b want=0", o_imem_req);
        end
        @(negedge i_clk);
        #2;
        n_checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_fails++;
            $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h",
                     o_imem_req, o_imem_addr, RST_PC);
        end
    endtask

    task automatic test_stream;
        logic [31:0] nxt = RST_PC + 32'd4;
        int nreq = 0;
        int bubbles = 0;
        for (int i = 1; i <= 24; i++) begin
            @(negedge i_clk);
            #2;
            if (o_imem_req && i_imem_gnt) begin
                nreq++;
                n_checks++;
                if (o_imem_addr !== nxt) begin
                    n_fails++; $display("FAIL stream_addr got=%h want=%h", o_imem_addr, nxt);
                end
                nxt = nxt + 32'd4;
            end
            if (i >= 2 && !o_valid) bubbles++;
        end
        n_checks++;
        if (nreq != 24) begin
            n_fails++; $display("FAIL stream_req_rate got=%0d want=24", nreq);
        end
        n_checks++;
        if (bubbles != 0) begin
            n_fails++; $display("FAIL stream_bubbles got=%0d want=0", bubbles);
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        @(negedge i_clk);
        i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #2;
            n_checks++;
            if (o_valid !== 1'b1 || o_pc_addr !== exp_q[0]) begin
                n_fails++;
                $display("FAIL stall_head got valid=%b pc=%h want valid=1 pc=%h",
                         o_valid, o_pc_addr, exp_q[0]);
            end
            @(negedge i_clk);
        end
        #2;
        n_checks++;
        if (o_imem_req !== 1'b0) begin
            n_fails++; $display("FAIL stall_full_req got=%b want=0", o_imem_req);
        end
        n_checks++;
        if (grant_cnt - pop_cnt != 4) begin
            n_fails++; $display("FAIL stall_occupancy got=%0d want=4", grant_cnt - pop_cnt);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (i == 1) begin
                n_checks++;
                if (o_imem_req !== 1'b1) begin
                    n_fails++; $display("FAIL restart_req got=%b want=1", o_imem_req);
                end
            end
            if (!o_valid) bad++;
            @(negedge i_clk);
        end
        n_checks++;
        if (bad != 0) begin
            n_fails++; $display("FAIL drain_bubbles got=%0d want=0", bad);
        end
    endtask

    task automatic drain;
        bit ok = 1'b0;
        @(negedge i_clk);
        gnt_en = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            #2;
            if (pend_addr.size() == 0 && !i_imem_rvalid && !o_valid) ok = 1'b1;
            else @(negedge i_clk);
        end
        n_checks++;
        if (!ok) begin
            n_fails++; $display("FAIL drain_timeout got=busy want=idle");
        end
    endtask

    task automatic test_redirect_latency;
        int waited = 0;
        bit found = 1'b0;
        drain();
        @(negedge i_clk);
        lat = 3;
        gnt_en = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        gnt_en = 1'b0;
        i_redirect = 1'b1;
        i_redirect_addr = 32'h0000_2003;
        load_stream(32'h0000_2000);
        @(negedge i_clk);
        i_redirect = 1'b0;
        gnt_en = 1'b1;
        #2;
        n_checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_2000) begin
            n_fails++;
            $display("FAIL redir_req got req=%b addr=%h want req=1 addr=00002000",
                     o_imem_req, o_imem_addr);
        end
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fails++; $display("FAIL redir_valid got=%b want=0", o_valid);
        end
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge i_clk);
            #2;
            waited++;
            if (o_valid) found = 1'b1;
        end
        n_checks++;
        if (!found || waited != 4 || o_pc_addr !== 32'h0000_2000) begin
            n_fails++;
            $display("FAIL redir_first got found=%b cycles=%0d pc=%h want 1 4 00002000",
                     found, waited, o_pc_addr);
        end
    endtask

    task automatic test_redirect_collision;
        drain();
        @(negedge i_clk);
        lat = 1;
        gnt_en = 1'b1;
        repeat (6) @(negedge i_clk);
        i_redirect = 1'b1;
        i_redirect_addr = 32'h0000_4000;
        load_stream(32'h0000_4000);
        #2;
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fails++; $display("FAIL coll_pre_valid got=%b want=1", o_valid);
        end
        @(negedge i_clk);
        i_redirect = 1'b0;
        #2;
        n_checks++;
        if (o_valid !== 1'b0 || o_inst_data !== NOP || o_pc_addr !== 32'h0) begin
            n_fails++;
            $display("FAIL coll_flush got valid=%b pc=%h inst=%h want 0 00000000 %h",
                     o_valid, o_pc_addr, o_inst_data, NOP);
        end
        @(negedge i_clk);
        #2;
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fails++; $display("FAIL coll_drop got=%b want=0", o_valid);
        end
        @(negedge i_clk);
        #2;
        n_checks++;
        if (o_valid !== 1'b1 || o_pc_addr !== 32'h0000_4000 ||
            o_inst_data !== inst_of(32'h0000_4000)) begin
            n_fails++;
            $display("FAIL coll_new got valid=%b pc=%h want valid=1 pc=00004000",
                     o_valid, o_pc_addr);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] want [3];
        int idx = 0;
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        @(negedge i_clk);
        i_redirect = 1'b1;
        i_redirect_addr = 32'hFFFF_FFF8;
        load_stream(32'hFFFF_FFF8);
        @(negedge i_clk);
        i_redirect = 1'b0;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            #2;
            if (o_imem_req && i_imem_gnt) begin
                n_checks++;
                if (o_imem_addr !== want[idx]) begin
                    n_fails++;
                    $display("FAIL wrap_addr%0d got=%h want=%h", idx, o_imem_addr, want[idx]);
                end
                idx++;
            end
            @(negedge i_clk);
        end
        n_checks++;
        if (idx != 3) begin
            n_fails++; $display("FAIL wrap_count got=%0d want=3", idx);
        end
        repeat (8) @(negedge i_clk);
    endtask

    task automatic test_reset_mid;
        int waited = 0;
        bit found = 1'b0;
        @(negedge i_clk);
        i_ready = 1'b0;
        gnt_en = 1'b0;
        @(negedge i_clk);
        #2;
        n_checks++;
        if (o_valid !== 1'b1 || o_pc_addr !== exp_q[0]) begin
            n_fails++;
            $display("FAIL mid_head got valid=%b pc=%h want valid=1 pc=%h",
                     o_valid, o_pc_addr, exp_q[0]);
        end
        @(negedge i_clk);
        #3;
        i_reset = 1'b0;
        #1;
        n_checks++;
        if (o_imem_req !== 1'b0 || o_imem_addr !== RST_PC) begin
            n_fails++;
            $display("FAIL mid_req got req=%b addr=%h want req=0 addr=%h",
                     o_imem_req, o_imem_addr, RST_PC);
        end
        n_checks++;
        if (o_valid !== 1'b0 || o_pc_addr !== 32'h0 || o_inst_data !== NOP) begin
            n_fails++;
            $display("FAIL mid_out got valid=%b pc=%h inst=%h want 0 00000000 %h",
                     o_valid, o_pc_addr, o_inst_data, NOP);
        end
        load_stream(RST_PC);
        gnt_en = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        #2;
        n_checks++;
        if (o_imem_req !== 1'b0) begin
            n_fails++; $display("FAIL mid_boot_req got=%b want=0", o_imem_req);
        end
        @(negedge i_clk);
        #2;
        n_checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin
            n_fails++;
            $display("FAIL mid_restart got req=%b addr=%h want req=1 addr=%h",
                     o_imem_req, o_imem_addr, RST_PC);
        end
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge i_clk);
            #2;
            waited++;
            if (o_valid) found = 1'b1;
        end
        n_checks++;
        if (!found || waited != 2 || o_pc_addr !== RST_PC) begin
            n_fails++;
            $display("FAIL mid_first got found=%b cycles=%0d pc=%h want 1 2 %h",
                     found, waited, o_pc_addr, RST_PC);
        end
    endtask

    initial begin
        i_reset         = 1'b0;
        i_ready         = 1'b1;
        i_redirect      = 1'b0;
        i_redirect_addr = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collision();
        test_wrap();
        test_reset_mid();
        repeat (6) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
